xbar_rr_scheduler: RTL and testbench
====================================

// Module: xbar_rr_scheduler
// PURPOSE
//  Parametrised crossbar scheduler for the switch datapath. Inspects the head header of each input FIFO
//  and grants per-output access with round-robin fairness. Drives the megamux selects, output RAM enables
//  and input FIFO read requests. Supports N ports, a configurable transfer window and discard of bad destinations.
// PARAMETERS
//  NUM_PORTS   3   input and output port count (2..8)
//  DATA_W      32  header word width; destination field is hdr[DEST_W-1:0]
//  USEDW_W     2   FIFO usedw width
//  XFER_CYCLES 1   cycles en/sel are held per grant (1..16)
//  DEFAULT_OUT 1   output index (0-based) used for destination code 0
//  DEST_W = $clog2(NUM_PORTS+1), SEL_W = $clog2(NUM_PORTS+1)   (localparams)
// PORTS
//  clk       in   1                   clock
//  reset     in   1                   synchronous, active-high reset
//  in_hdr    in   [NUM_PORTS][DATA_W]  head-of-FIFO header per input
//  in_usedw  in   [NUM_PORTS][USEDW_W] FIFO fill per input; nonzero = header valid
//  sel       out  [NUM_PORTS][SEL_W]   per output: granted input index+1; 0 = none
//  en        out  [NUM_PORTS]          per-output RAM/mux enable
//  rdreq     out  [NUM_PORTS]          per-input FIFO pop, 1-cycle pulse
//  busy      out  1                    high while in HOLD
// BEHAVIOUR
//  Reset: sel=0, en=0, rdreq=0, busy=0, state=SCHED, all RR pointers=0, XFER counter=0, stats=0.
//  Reset asserted mid-HOLD aborts the grant on the next edge. No pop is replayed.
//  Destination decode (dest = hdr[DEST_W-1:0]):
//    0 -> DEFAULT_OUT; 1..NUM_PORTS -> output dest-1; >NUM_PORTS -> DROP.
//  Input i requests its decoded output when in_usedw[i]!=0. Each input requests at most one output,
//  so an input never receives two grants.
//  Arbitration, per output o: the winner is the first requester at or after rr[o], searching cyclically.
//    On a grant, rr[o] <= winner+1 mod NUM_PORTS. rr[o] is unchanged when output o has no grant.
//  FSM SCHED: at the edge, register the grants:
//    - en[o]=1 and sel[o]=winner+1 for each output with a winner.
//    - rdreq[i]=1 for each winner and for each valid DROP input (discarded; no en).
//    If any rdreq is set -> HOLD, cnt=XFER_CYCLES-1, busy=1. Otherwise stay in SCHED with all outputs 0.
//  FSM HOLD: rdreq=0, and en/sel are held.
//    If cnt==0: clear en/sel, busy=0, -> SCHED. Otherwise cnt--.
//    Inputs are ignored in HOLD.
//  Result: grant outputs are visible for XFER_CYCLES cycles, followed by a one-cycle gap.
//    XFER_CYCLES=1 alternates grant/idle.
//  Latency: header valid at edge k -> rdreq/en/sel high after edge k (SCHED).
//  All outputs are registered. There are no combinational input-to-output paths.
// CONFIGURATION
//  SCHED_STATS_EN defined:
//    - adds out grant_cnt [NUM_PORTS][16], +1 per granted output per SCHED edge.
//    - adds out drop_cnt [16], +number of DROP pops per SCHED edge.
//    - Both counters saturate at 16'hFFFF and are cleared by reset.
//  SCHED_STATS_EN undefined: these ports and their counters are absent. All other behaviour is identical.
// STRUCTURE
//  Package xbar_pkg:
//    - dest_t/sel_t typedefs and SEL_NONE=0
//    - sched_state_e {SCHED,HOLD}
//    - function decode_dest(hdr, NUM_PORTS, DEFAULT_OUT) returning {drop, out_idx}
//  Sub-module rr_arbiter #(NUM_REQ):
//    - inputs req[NUM_REQ], ptr, grant_cycle
//    - outputs one-hot gnt, gnt_idx, valid, and the next pointer
//    - one instance per output
//  Top: decode, request matrix transpose, FSM, registers, optional stats.
// TESTING
//  1 Reset, all usedw=0 for 10 cycles -> en/sel/rdreq/busy stay 0. State stays SCHED.
//  2 N=3, hdr0 dest=1, hdr1 dest=2, hdr2 dest=3, usedw=1 each
//    -> one cycle later sel={1,2,3}, en=3'b111, rdreq=3'b111. Next cycle all 0.
//  3 Inputs 0,1,2 all dest=2, held valid 6 SCHED slots -> sel[1] sequence 1,2,3,1,2,3. rdreq one input per grant.
//  4 hdr0 dest=0, hdr1 dest=3 with NUM_PORTS=2 -> en[DEFAULT_OUT]=1, sel=1.
//    rdreq[1]=1 with no en. drop_cnt=1 under SCHED_STATS_EN.
//  5 XFER_CYCLES=4, single grant -> en high exactly 4 cycles, rdreq high 1 cycle, busy 4 cycles, then 1 idle.
//  6 reset pulsed during HOLD cycle 2 -> next cycle all outputs 0 and rr pointers 0.
//    A subsequent contention test restarts the sequence at input 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar round-robin scheduler.
// Holds the destination decode so every user maps header codes the same way.
package xbar_pkg;

  localparam int MAX_PORTS = 8;
  localparam int MAX_SEL_W = 4;

  typedef logic [MAX_SEL_W-1:0] dest_t;
  typedef logic [MAX_SEL_W-1:0] sel_t;

  localparam sel_t SEL_NONE = '0;

  typedef enum logic {
    SCHED = 1'b0,
    HOLD  = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic       drop;
    logic [2:0] out_idx;
  } dest_dec_t;

  // Map a destination code to an output: 0 goes to the default output,
  // 1..num_ports address output code-1, anything larger is discarded.
  function automatic dest_dec_t decode_dest(input dest_t hdr, input int num_ports,
                                            input int default_out);
    dest_dec_t r;
    r.drop    = 1'b0;
    r.out_idx = '0;
    if (hdr == '0) begin
      r.out_idx = 3'(default_out);
    end else if (int'(hdr) <= num_ports) begin
      r.out_idx = 3'(int'(hdr) - 1);
    end else begin
      r.drop = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xbar_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter for one crossbar output.
// The winner is the first requester at or after ptr, scanning cyclically;
// next_ptr points one past the winner, or stays at ptr when nothing is granted.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               grant_cycle,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               valid,
  output logic [IDX_W-1:0]   next_ptr
);

  int idx;

  // Cyclic priority search starting at the pointer.
  always_comb begin
    idx      = 0;
    gnt      = '0;
    gnt_idx  = '0;
    valid    = 1'b0;
    next_ptr = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!valid && grant_cycle && req[idx]) begin
        valid    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        next_ptr = IDX_W'((idx + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/xbar_rr_scheduler.sv
// Crossbar scheduler: decodes each input FIFO head header, arbitrates each
// output round-robin, and drives mux selects, output enables and FIFO pops.
// Optional per-output grant and drop statistics are built when the macro
// SCHED_STATS_EN is defined.
//
// Handshake: an input presents a valid header whenever in_usedw != 0; the
// header is consumed exactly when rdreq pulses for one cycle, and inputs are
// not sampled again until the grant window has closed.
module xbar_rr_scheduler
  import xbar_pkg::*;
#(
  parameter int NUM_PORTS   = 3,
  parameter int DATA_W      = 32,
  parameter int USEDW_W     = 2,
  parameter int XFER_CYCLES = 1,
  parameter int DEFAULT_OUT = 1,
  localparam int DEST_W     = $clog2(NUM_PORTS + 1),
  localparam int SEL_W      = $clog2(NUM_PORTS + 1),
  localparam int IDX_W      = $clog2(NUM_PORTS),
  localparam int CNT_W      = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS*DATA_W-1:0]  in_hdr,
  input  logic [NUM_PORTS*USEDW_W-1:0] in_usedw,
  output logic [NUM_PORTS*SEL_W-1:0]   sel,
  output logic [NUM_PORTS-1:0]         en,
  output logic [NUM_PORTS-1:0]         rdreq,
`ifdef SCHED_STATS_EN
  output logic [NUM_PORTS*16-1:0]      grant_cnt,
  output logic [15:0]                  drop_cnt,
`endif
  output logic                         busy,
  output logic                         dbg_state
);

  sched_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_PORTS*SEL_W-1:0] sel_d;
  logic [NUM_PORTS-1:0] en_d, rdreq_d;
  logic busy_d;

  dest_dec_t dec [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_valid, in_drop;
  logic [NUM_PORTS-1:0] req_mat [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt [NUM_PORTS];
  logic [IDX_W-1:0] gnt_idx [NUM_PORTS];
  logic [IDX_W-1:0] rr_q [NUM_PORTS];
  logic [IDX_W-1:0] rr_next [NUM_PORTS];
  logic [IDX_W-1:0] rr_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_valid;

  // Only the destination field of each header matters to scheduling.
  logic unused_hdr;
  assign unused_hdr = ^in_hdr;

  assign dbg_state = state_q;

  // Decode each head header into a destination or a discard.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dec[i]      = decode_dest(dest_t'(in_hdr[i*DATA_W +: DEST_W]), NUM_PORTS, DEFAULT_OUT);
      in_valid[i] = in_usedw[i*USEDW_W +: USEDW_W] != '0;
      in_drop[i]  = in_valid[i] & dec[i].drop;
    end
  end

  // Transpose per-input destinations into per-output request vectors.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req_mat[o][i] = in_valid[i] & ~dec[i].drop & (dec[i].out_idx == 3'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter #(.NUM_REQ(NUM_PORTS)) u_arb (
      .req         (req_mat[o]),
      .ptr         (rr_q[o]),
      .grant_cycle (state_q == SCHED),
      .gnt         (gnt[o]),
      .gnt_idx     (gnt_idx[o]),
      .valid       (gnt_valid[o]),
      .next_ptr    (rr_next[o])
    );
  end

  // Next-state and registered-output logic for the SCHED/HOLD FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel;
    en_d    = en;
    rdreq_d = '0;
    busy_d  = busy;
    rr_d    = rr_q;
    case (state_q)
      SCHED: begin
        sel_d  = '0;
        en_d   = '0;
        busy_d = 1'b0;
        for (int o = 0; o < NUM_PORTS; o++) begin
          if (gnt_valid[o]) begin
            en_d[o]                 = 1'b1;
            sel_d[o*SEL_W +: SEL_W] = SEL_W'(gnt_idx[o]) + SEL_W'(1);
            rdreq_d                 = rdreq_d | gnt[o];
          end
        end
        // Bad destinations are popped and discarded without an enable.
        rdreq_d = rdreq_d | in_drop;
        if (|rdreq_d) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(XFER_CYCLES - 1);
          busy_d  = 1'b1;
          rr_d    = rr_next;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = SCHED;
          sel_d   = '0;
          en_d    = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = SCHED;
    endcase
  end

  // State, grant outputs and round-robin pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCHED;
      cnt_q   <= '0;
      sel     <= '0;
      en      <= '0;
      rdreq   <= '0;
      busy    <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) rr_q[o] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel     <= sel_d;
      en      <= en_d;
      rdreq   <= rdreq_d;
      busy    <= busy_d;
      for (int o = 0; o < NUM_PORTS; o++) rr_q[o] <= rr_d[o];
    end
  end

`ifdef SCHED_STATS_EN
  logic [16:0] drop_sum;

  // Saturating sum of discarded pops this cycle.
  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < NUM_PORTS; i++) drop_sum = drop_sum + 17'(in_drop[i]);
    if (drop_sum > 17'h0FFFF) drop_sum = 17'h0FFFF;
  end

  // Grant and drop counters, updated only on scheduling edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
      drop_cnt  <= '0;
    end else if (state_q == SCHED) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (gnt_valid[o] && grant_cnt[o*16 +: 16] != 16'hFFFF)
          grant_cnt[o*16 +: 16] <= grant_cnt[o*16 +: 16] + 16'd1;
      end
      drop_cnt <= drop_sum[15:0];
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// Bench for xbar_rr_scheduler: two instances (3 ports / 1-cycle window and
// 2 ports / 4-cycle window) checked against a slot-level reference model.
module tb_xbar_rr_scheduler;

  localparam int NA = 3, XA = 1, NB = 2, XB = 4, DEF = 1;
  localparam int DW = 32, UW = 2, SW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NA*DW-1:0] hdr_a = '0;
  logic [NA*UW-1:0] usedw_a = '0;
  logic [NA*SW-1:0] sel_a;
  logic [NA-1:0]    en_a, rdreq_a;
  logic             busy_a, st_a;
  logic [NB*DW-1:0] hdr_b = '0;
  logic [NB*UW-1:0] usedw_b = '0;
  logic [NB*SW-1:0] sel_b;
  logic [NB-1:0]    en_b, rdreq_b;
  logic             busy_b, st_b;
`ifdef SCHED_STATS_EN
  logic [NA*16-1:0] gcnt_a;
  logic [15:0]      dcnt_a;
  logic [NB*16-1:0] gcnt_b;
  logic [15:0]      dcnt_b;
`endif

  xbar_rr_scheduler #(.NUM_PORTS(NA), .DATA_W(DW), .USEDW_W(UW), .XFER_CYCLES(XA),
                      .DEFAULT_OUT(DEF)) dut_a (
    .clk(clk), .reset(reset), .in_hdr(hdr_a), .in_usedw(usedw_a),
    .sel(sel_a), .en(en_a), .rdreq(rdreq_a),
`ifdef SCHED_STATS_EN
    .grant_cnt(gcnt_a), .drop_cnt(dcnt_a),
`endif
    .busy(busy_a), .dbg_state(st_a));

  xbar_rr_scheduler #(.NUM_PORTS(NB), .DATA_W(DW), .USEDW_W(UW), .XFER_CYCLES(XB),
                      .DEFAULT_OUT(DEF)) dut_b (
    .clk(clk), .reset(reset), .in_hdr(hdr_b), .in_usedw(usedw_b),
    .sel(sel_b), .en(en_b), .rdreq(rdreq_b),
`ifdef SCHED_STATS_EN
    .grant_cnt(gcnt_b), .drop_cnt(dcnt_b),
`endif
    .busy(busy_b), .dbg_state(st_b));

  // ---------------- reference model ----------------
  int cfg, cfg_n, cfg_x;
  logic [31:0] m_hdr [8];
  int  m_used [8];
  int  m_hold;
  int  m_rr [8];
  int  m_sel [8];
  bit  m_rdreq [8];
  bit  m_busy;
  int  m_gcnt [8];
  int  m_dcnt;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cfg=%0d t=%0t got=%0h exp=%0h", tag, cfg, $time, got, exp);
    end
  endtask

  // Output index for a header, or -1 when the destination code is out of range.
  function automatic int model_dest(input logic [31:0] h);
    int destw, d;
    destw = $clog2(cfg_n + 1);
    d = int'(h & ((32'd1 << destw) - 32'd1));
    if (d == 0) return DEF;
    if (d <= cfg_n) return d - 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_busy = 0; m_dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      m_rr[i] = 0; m_sel[i] = 0; m_rdreq[i] = 0; m_gcnt[i] = 0;
    end
  endtask

  // One clock edge of the scheduler's observable behaviour.
  task automatic model_step();
    bit any;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 8; i++) m_rdreq[i] = 0;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        for (int o = 0; o < 8; o++) m_sel[o] = 0;
        m_busy = 0;
      end
      return;
    end
    any = 0;
    for (int o = 0; o < 8; o++) m_sel[o] = 0;
    for (int i = 0; i < cfg_n; i++) begin
      if (m_used[i] != 0 && model_dest(m_hdr[i]) < 0) begin
        m_rdreq[i] = 1; any = 1;
        if (m_dcnt < 16'hFFFF) m_dcnt++;
      end
    end
    for (int o = 0; o < cfg_n; o++) begin
      for (int k = 0; k < cfg_n; k++) begin
        int i;
        i = (m_rr[o] + k) % cfg_n;
        if (m_used[i] != 0 && model_dest(m_hdr[i]) == o) begin
          m_sel[o] = i + 1; m_rdreq[i] = 1; any = 1;
          m_rr[o] = (i + 1) % cfg_n;
          if (m_gcnt[o] < 16'hFFFF) m_gcnt[o]++;
          break;
        end
      end
    end
    m_busy = any;
    m_hold = any ? cfg_x : 0;
  endtask

  task automatic compare();
    logic [31:0] es, ee, er, gs, ge, gr, gb, gst;
    es = 0; ee = 0; er = 0;
    for (int o = 0; o < cfg_n; o++) begin
      es = es | (32'(m_sel[o]) << (o * SW));
      if (m_sel[o] != 0) ee[o] = 1'b1;
      if (m_rdreq[o]) er[o] = 1'b1;
    end
    if (cfg == 0) begin
      gs = 32'(sel_a); ge = 32'(en_a); gr = 32'(rdreq_a); gb = 32'(busy_a); gst = 32'(st_a);
    end else begin
      gs = 32'(sel_b); ge = 32'(en_b); gr = 32'(rdreq_b); gb = 32'(busy_b); gst = 32'(st_b);
    end
    check("sel", gs, es);
    check("en", ge, ee);
    check("rdreq", gr, er);
    check("busy", gb, 32'(m_busy));
    check("state", gst, 32'(m_hold > 0));
`ifdef SCHED_STATS_EN
    for (int o = 0; o < cfg_n; o++)
      check("grant_cnt", (cfg == 0) ? 32'(gcnt_a[o*16 +: 16]) : 32'(gcnt_b[o*16 +: 16]),
            32'(m_gcnt[o]));
    check("drop_cnt", (cfg == 0) ? 32'(dcnt_a) : 32'(dcnt_b), 32'(m_dcnt));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic set_in(input int i, input int dest, input int used);
    logic [31:0] h;
    h = ($urandom << 2) | 32'(dest & 3);
    m_hdr[i] = h;
    m_used[i] = used;
    if (cfg == 0) begin
      hdr_a[i*DW +: DW] = h;
      usedw_a[i*UW +: UW] = UW'(used);
    end else begin
      hdr_b[i*DW +: DW] = h;
      usedw_b[i*UW +: UW] = UW'(used);
    end
  endtask

  task automatic clear_in();
    for (int i = 0; i < cfg_n; i++) set_in(i, 0, 0);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic random_run(input int n_cycles);
    for (int c = 0; c < n_cycles; c++) begin
      for (int i = 0; i < cfg_n; i++)
        set_in(i, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3));
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
  endtask

  // ---------------- scenario ----------------
  initial begin
    cfg = 0; cfg_n = NA; cfg_x = XA;
    for (int i = 0; i < 8; i++) begin m_hdr[i] = '0; m_used[i] = 0; end
    model_reset();
    reset = 1'b1;
    #1;
    repeat (2) cycle();
    reset = 1'b0;

    // Idle after reset: nothing granted, FSM stays in SCHED.
    repeat (10) cycle();
    check("t1_idle_en", 32'(en_a), 32'd0);

    // Three disjoint destinations: full parallel grant, then a gap cycle.
    set_in(0, 1, 1); set_in(1, 2, 1); set_in(2, 3, 1);
    cycle();
    check("t2_sel", 32'(sel_a), 32'h39);
    check("t2_en", 32'(en_a), 32'h7);
    check("t2_rdreq", 32'(rdreq_a), 32'h7);
    clear_in();
    cycle();
    check("t2_gap", 32'({sel_a, en_a, rdreq_a}), 32'd0);

    // Three inputs contending for output 1 rotate 1,2,3,1,2,3.
    reset_pulse();
    for (int k = 0; k < 6; k++) exp_q.push_back(32'((k % 3) + 1));
    set_in(0, 2, 1); set_in(1, 2, 1); set_in(2, 2, 1);
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (rdreq_a != '0) begin
        check("t3_one_pop", 32'($countones(rdreq_a)), 32'd1);
        if (exp_q.size() > 0) check("t3_rr_seq", 32'(sel_a[3:2]), exp_q.pop_front());
      end
    end
    check("t3_all_grants", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    clear_in();
    cycle();

    // Two-port instance: default route plus a discarded header, 4-cycle window.
    cfg = 1; cfg_n = NB; cfg_x = XB;
    reset_pulse();
    set_in(0, 0, 1); set_in(1, 3, 2);
    cycle();
    check("t4_en", 32'(en_b), 32'h2);
    check("t4_sel", 32'(sel_b), 32'h4);
    check("t4_rdreq", 32'(rdreq_b), 32'h3);
`ifdef SCHED_STATS_EN
    check("t4_drop_cnt", 32'(dcnt_b), 32'd1);
`endif
    clear_in();
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("t5_en_held", 32'(en_b), 32'h2);
      check("t5_busy_held", 32'(busy_b), 32'd1);
      check("t5_no_pop", 32'(rdreq_b), 32'd0);
    end
    cycle();
    check("t5_gap_en", 32'(en_b), 32'd0);
    check("t5_gap_busy", 32'(busy_b), 32'd0);

    // Reset in the middle of a window clears outputs and pointers.
    set_in(0, 2, 1);
    cycle();
    clear_in();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6_reset_out", 32'({sel_b, en_b, rdreq_b, busy_b}), 32'd0);
    for (int k = 0; k < 4; k++) exp_q.push_back(32'((k % 2) + 1));
    set_in(0, 2, 1); set_in(1, 2, 1);
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (rdreq_b != '0 && exp_q.size() > 0) check("t6_rr_restart", 32'(sel_b[3:2]), exp_q.pop_front());
    end
    check("t6_all_grants", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    clear_in();

    // Random traffic on both instances.
    random_run(400);
    cfg = 0; cfg_n = NA; cfg_x = XA;
    reset_pulse();
    random_run(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
